// File: rtl/adder_operand_sweep.sv
// Walks every (a, b) operand pair in row-major order into a combinational adder
// and accumulates the returned {carry, sum} plus an accepted-pair count.
module adder_operand_sweep #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned ACC_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic               ready,
  output logic [WIDTH-1:0]   a,
  output logic [WIDTH-1:0]   b,
  output logic               valid,
  output logic               last,
  input  logic [WIDTH-1:0]   sum,
  input  logic               carry,
  output logic [ACC_W-1:0]   acc,
  output logic [2*WIDTH:0]   count,
  output logic               busy,
  output logic               done
);

  localparam int unsigned CNT_W = 2 * WIDTH + 1;
  localparam logic [WIDTH-1:0] MAX_OP = {WIDTH{1'b1}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_d;
  logic [WIDTH-1:0]   a_d, b_d;
  logic [ACC_W-1:0]   acc_d;
  logic [CNT_W-1:0]   count_d;
  logic               xfer;

  assign last = valid && (a == MAX_OP) && (b == MAX_OP);

  // Next-state and datapath update; abort overrides everything else.
  always_comb begin
    state_d = state;
    a_d     = a;
    b_d     = b;
    acc_d   = acc;
    count_d = count;
    xfer    = (state == RUN) && ready;

    if (abort) begin
      state_d = IDLE;
      a_d     = '0;
      b_d     = '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state_d = RUN;
            a_d     = '0;
            b_d     = '0;
            acc_d   = '0;
            count_d = '0;
          end
        end
        RUN: begin
          if (xfer) begin
            acc_d   = acc + ACC_W'({carry, sum});
            count_d = count + CNT_W'(1);
            if (last) begin
              state_d = DONE;
              a_d     = '0;
              b_d     = '0;
            end else if (b == MAX_OP) begin
              b_d = '0;
              a_d = a + WIDTH'(1);
            end else begin
              b_d = b + WIDTH'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers; status flags are registered decodes of next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a     <= '0;
      b     <= '0;
      acc   <= '0;
      count <= '0;
      valid <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_d;
      a     <= a_d;
      b     <= b_d;
      acc   <= acc_d;
      count <= count_d;
      valid <= (state_d == RUN);
      busy  <= (state_d == RUN);
      done  <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_adder_operand_sweep.sv
// Directed bench for adder_operand_sweep at WIDTH=2 with a behavioural adder.
module tb_adder_operand_sweep;

  localparam int unsigned WIDTH = 2;
  localparam int unsigned ACC_W = 32;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic               abort;
  logic               ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               valid;
  logic               last;
  logic [WIDTH-1:0]   sum;
  logic               carry;
  logic [ACC_W-1:0]   acc;
  logic [2*WIDTH:0]   count;
  logic               busy;
  logic               done;
  logic               zero_res;

  int checks = 0;
  int errors = 0;

  adder_operand_sweep #(.WIDTH(WIDTH), .ACC_W(ACC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .abort (abort),
    .ready (ready),
    .a     (a),
    .b     (b),
    .valid (valid),
    .last  (last),
    .sum   (sum),
    .carry (carry),
    .acc   (acc),
    .count (count),
    .busy  (busy),
    .done  (done)
  );

  // Behavioural adder, optionally forced to zero.
  assign {carry, sum} = zero_res ? '0 : ({1'b0, a} + {1'b0, b});

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one sweep already in RUN at (0,0); checks order, last and stalls.
  task automatic run_sweep(input bit rand_ready, input bit poke_start);
    int n   = 0;
    int cyc = 0;
    while (n < 16 && cyc < 200) begin
      ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      start = (poke_start && n < 15) ? 1'b1 : 1'b0;
      chk("pair", 32'({a, b}), 32'(n));
      chk("last", 32'(last), 32'(n == 15));
      chk("valid_run", 32'(valid), 32'd1);
      tick();
      if (ready) n++;
      cyc++;
    end
    ready = 1'b0;
    start = 1'b0;
    chk("sweep_bound", 32'(n), 32'd16);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    ready    = 1'b0;
    zero_res = 1'b0;
    #3;
    chk("reset_outs", 32'({a, b, valid, last, acc[3:0], count, busy, done}), 32'd0);
    chk("reset_acc", acc, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("idle_after_reset", 32'({valid, busy, done}), 32'd0);

    // Sweep 1: random ready, real sums.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("first_valid", 32'({valid, busy, done}), 32'b110);
    run_sweep(1'b1, 1'b0);
    chk("done1", 32'({valid, busy, done}), 32'b001);
    chk("acc1", acc, 32'd48);
    chk("count1", 32'(count), 32'd16);
    chk("ab_wrap", 32'({a, b}), 32'd0);
    tick();
    chk("done_hold", 32'(done), 32'd1);
    chk("acc_frozen", acc, 32'd48);

    // Sweep 2: zeroed results, ready held, start poked during RUN.
    zero_res = 1'b1;
    start    = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_valid", 32'({valid, done}), 32'b10);
    chk("restart_clear", 32'({acc[3:0], count}), 32'd0);
    run_sweep(1'b0, 1'b1);
    chk("acc_zero", acc, 32'd0);
    chk("count2", 32'(count), 32'd16);
    chk("done2", 32'(done), 32'd1);
    zero_res = 1'b0;

    // start and abort together in DONE.
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("abort_wins", 32'({valid, busy, done}), 32'd0);
    chk("abort_keep_cnt", 32'(count), 32'd16);

    // Abort after five transfers.
    start = 1'b1;
    tick();
    start = 1'b0;
    ready = 1'b1;
    repeat (5) tick();
    ready = 1'b0;
    chk("five_pos", 32'({a, b}), 32'b0101);
    chk("five_cnt", 32'(count), 32'd5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_state", 32'({valid, busy, done}), 32'd0);
    chk("abort_ab", 32'({a, b}), 32'd0);
    chk("abort_cnt", 32'(count), 32'd5);
    chk("abort_acc", acc, 32'd7);
    tick();
    chk("idle_stays", 32'(valid), 32'd0);

    // Restart, then asynchronous reset mid-cycle.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart2", 32'({a, b, valid, count}), 32'({4'b0000, 1'b1, 5'd0}));
    chk("restart2_acc", acc, 32'd0);
    ready = 1'b1;
    repeat (3) tick();
    chk("pre_reset_cnt", 32'(count), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", 32'({a, b, valid, last, count, busy, done}), 32'd0);
    chk("async_reset_acc", acc, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    chk("post_reset_idle", 32'({valid, busy, done, count}), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
